// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, hazard and redirect controls from later
// stages, and the IF/ID register contents handed to decode.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  oRomAddress;
  logic [INSTR_WIDTH-1:0] iRomInstruction;
  logic                   iStall;
  logic                   iBranchTaken;
  logic [ADDR_WIDTH-1:0]  iBranchTarget;
  logic                   iHalt;
  logic [INSTR_WIDTH-1:0] oIfIdInstruction;
  logic [ADDR_WIDTH-1:0]  oIfIdPC;
  logic                   oIfIdValid;
  logic                   oHalted;
  logic [COUNT_WIDTH-1:0] oFetchCount;

  modport master (
    output oRomAddress,
    input  iRomInstruction,
    input  iStall,
    input  iBranchTaken,
    input  iBranchTarget,
    input  iHalt,
    output oIfIdInstruction,
    output oIfIdPC,
    output oIfIdValid,
    output oHalted,
    output oFetchCount
  );

  modport slave (
    input  oRomAddress,
    output iRomInstruction,
    output iStall,
    output iBranchTaken,
    output iBranchTarget,
    output iHalt,
    input  oIfIdInstruction,
    input  oIfIdPC,
    input  oIfIdValid,
    input  oHalted,
    input  oFetchCount
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, addresses the combinational instruction ROM and fills
// the IF/ID register, with stall, redirect/squash, halt and a fetch counter.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int COUNT_WIDTH = 16
) (
  input logic Clock,
  input logic Reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [5:0] NOP_OPCODE = 6'd0;
  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR =
    {NOP_OPCODE, {(INSTR_WIDTH-6){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0]  PC_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_ONE;
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;

    case (state_q)
      // One settling cycle so the ROM output reflects RESET_PC before the first capture.
      S_BOOT: begin
        state_d      = S_RUN;
        ifid_instr_d = BUBBLE_INSTR;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
      end
      S_RUN: begin
        if (bus.iBranchTaken) begin
          pc_d         = bus.iBranchTarget;
          ifid_instr_d = BUBBLE_INSTR;
          ifid_pc_d    = '0;
          ifid_valid_d = 1'b0;
        end else if (bus.iHalt) begin
          state_d      = S_HALT;
          ifid_instr_d = BUBBLE_INSTR;
          ifid_pc_d    = '0;
          ifid_valid_d = 1'b0;
        end else if (!bus.iStall) begin
          ifid_instr_d = bus.iRomInstruction;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_ONE;
          count_d      = sat_inc(count_q);
        end
      end
      S_HALT: begin
        ifid_instr_d = BUBBLE_INSTR;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
        if (bus.iBranchTaken) pc_d = bus.iBranchTarget;
        if (!bus.iHalt) state_d = S_RUN;
      end
      default: begin
        state_d      = S_BOOT;
        ifid_instr_d = BUBBLE_INSTR;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  assign bus.oRomAddress      = pc_q;
  assign bus.oIfIdInstruction = ifid_instr_q;
  assign bus.oIfIdPC          = ifid_pc_q;
  assign bus.oIfIdValid       = ifid_valid_q;
  assign bus.oHalted          = halted_q;
  assign bus.oFetchCount      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the main
// sequence plus hand-written wrap, saturation and mid-run reset sequences.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_WIDTH(10), .INSTR_WIDTH(16), .COUNT_WIDTH(16)) bus ();
  instruction_fetch_unit_if #(.ADDR_WIDTH(10), .INSTR_WIDTH(16), .COUNT_WIDTH(4))  bus4 ();

  instruction_fetch_unit #(.ADDR_WIDTH(10), .INSTR_WIDTH(16), .RESET_PC(10'd0), .COUNT_WIDTH(16))
    dut (.Clock(clk), .Reset(rst), .bus(bus));

  instruction_fetch_unit #(.ADDR_WIDTH(10), .INSTR_WIDTH(16), .RESET_PC(10'd0), .COUNT_WIDTH(4))
    dut4 (.Clock(clk), .Reset(rst), .bus(bus4));

  function automatic logic [15:0] rom_word(input logic [9:0] a);
    return {a[5:0] ^ 6'h2A, a};
  endfunction

  assign bus.iRomInstruction  = rom_word(bus.oRomAddress);
  assign bus4.iRomInstruction = rom_word(bus4.oRomAddress);
  assign bus4.iStall          = bus.iStall;
  assign bus4.iBranchTaken    = bus.iBranchTaken;
  assign bus4.iBranchTarget   = bus.iBranchTarget;
  assign bus4.iHalt           = bus.iHalt;

  typedef struct {
    logic        stall;
    logic        br;
    logic [9:0]  tgt;
    logic        halt;
    logic        valid;
    logic [9:0]  pc;
    logic [9:0]  ra;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic add(input logic s, input logic b, input logic [9:0] t, input logic h,
                     input logic v, input logic [9:0] pc, input logic [9:0] ra,
                     input logic hd, input logic [15:0] c);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.halt = h;
    x.valid = v; x.pc = pc; x.ra = ra; x.halted = hd; x.cnt = c;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one vector, clock it, then compare the registered outputs.
  task automatic apply(input string tag, input vec_t x);
    logic [15:0] exp_instr;
    bus.iStall        = x.stall;
    bus.iBranchTaken  = x.br;
    bus.iBranchTarget = x.tgt;
    bus.iHalt         = x.halt;
    @(posedge clk);
    #1;
    exp_instr = x.valid ? rom_word(x.pc) : 16'h0000;
    chk({tag, ".valid"},  32'(bus.oIfIdValid),       32'(x.valid));
    chk({tag, ".ifidpc"}, 32'(bus.oIfIdPC),          32'(x.pc));
    chk({tag, ".instr"},  32'(bus.oIfIdInstruction), 32'(exp_instr));
    chk({tag, ".romadr"}, 32'(bus.oRomAddress),      32'(x.ra));
    chk({tag, ".halted"}, 32'(bus.oHalted),          32'(x.halted));
    chk({tag, ".count"},  32'(bus.oFetchCount),      32'(x.cnt));
  endtask

  initial begin
    vec_t x;
    bus.iStall = 1'b0; bus.iBranchTaken = 1'b0; bus.iBranchTarget = '0; bus.iHalt = 1'b0;

    // Boot edge, then free run delivering PC 0..12.
    add(0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k <= 12; k++) add(0,0,0,0, 1,10'(k),10'(k+1),0,16'(k+1));
    // Redirect to 4, deliver 4, stall three cycles, release.
    add(0,1,4,0, 0,0,4,0,13);
    add(0,0,0,0, 1,4,5,0,14);
    for (int k = 0; k < 3; k++) add(1,0,0,0, 1,4,5,0,14);
    add(0,0,0,0, 1,5,6,0,15);
    add(0,0,0,0, 1,6,7,0,16);
    // Branch at PC 7 with stall also high: squash, then 2..8.
    add(1,1,2,0, 0,0,2,0,16);
    for (int k = 2; k <= 8; k++) add(0,0,0,0, 1,10'(k),10'(k+1),0,16'(k+15));
    // Branch wins over halt; then four halted cycles with branches and a stall.
    add(0,1,9,1,  0,0,9,0,23);
    add(0,0,0,1,  0,0,9,1,23);
    add(0,1,20,1, 0,0,20,1,23);
    add(0,1,9,1,  0,0,9,1,23);
    add(1,0,0,1,  0,0,9,1,23);
    add(0,0,0,0,  0,0,9,0,23);
    add(0,0,0,0,  1,9,10,0,24);
    add(0,0,0,0,  1,10,11,0,25);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid",  32'(bus.oIfIdValid),       32'd0);
    chk("reset.ifidpc", 32'(bus.oIfIdPC),          32'd0);
    chk("reset.instr",  32'(bus.oIfIdInstruction), 32'd0);
    chk("reset.romadr", 32'(bus.oRomAddress),      32'd0);
    chk("reset.halted", 32'(bus.oHalted),          32'd0);
    chk("reset.count",  32'(bus.oFetchCount),      32'd0);
    chk("reset.count4", 32'(bus4.oFetchCount),     32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("row%0d", i), vecs[i]);
    chk("sat.count4", 32'(bus4.oFetchCount), 32'd15);

    // PC wrap: 1022, 1023, 0.
    x = '{stall:0, br:1, tgt:10'd1022, halt:0, valid:0, pc:0,    ra:10'd1022, halted:0, cnt:25};
    apply("wrap0", x);
    x = '{stall:0, br:0, tgt:0, halt:0, valid:1, pc:10'd1022, ra:10'd1023, halted:0, cnt:26};
    apply("wrap1", x);
    x = '{stall:0, br:0, tgt:0, halt:0, valid:1, pc:10'd1023, ra:10'd0,    halted:0, cnt:27};
    apply("wrap2", x);
    x = '{stall:0, br:0, tgt:0, halt:0, valid:1, pc:10'd0,    ra:10'd1,    halted:0, cnt:28};
    apply("wrap3", x);
    chk("sat.count4b", 32'(bus4.oFetchCount), 32'd15);

    // Reach PC 300, then reset with a branch pending.
    x = '{stall:0, br:1, tgt:10'd299, halt:0, valid:0, pc:0, ra:10'd299, halted:0, cnt:28};
    apply("mid0", x);
    x = '{stall:0, br:0, tgt:0, halt:0, valid:1, pc:10'd299, ra:10'd300, halted:0, cnt:29};
    apply("mid1", x);
    rst = 1'b1;
    x = '{stall:0, br:1, tgt:10'd50, halt:0, valid:0, pc:0, ra:10'd0, halted:0, cnt:0};
    apply("midrst", x);
    chk("midrst.count4", 32'(bus4.oFetchCount), 32'd0);
    rst = 1'b0;
    x = '{stall:0, br:0, tgt:0, halt:0, valid:0, pc:0, ra:10'd0, halted:0, cnt:0};
    apply("reboot", x);
    x = '{stall:0, br:0, tgt:0, halt:0, valid:1, pc:0, ra:10'd1, halted:0, cnt:1};
    apply("refetch", x);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
